// File: rtl/frame_loader_ctrl_if.sv
// Stream bundle carrying frame words into frame_loader_ctrl.
// Handshake: a word moves on a rising edge where s_valid and s_ready are both high; the master holds s_data while s_valid waits.
interface frame_loader_ctrl_if #(
  parameter int W = 32
) ();
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_loader_ctrl.sv
// Frame loader: takes frame words from a valid/ready stream and pulses one FrameStrobe bit per word.
// Define FRAME_LOADER_CHECKSUM_EN to require a trailing checksum word (32-bit running sum) after the last frame.
module frame_loader_ctrl #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int STROBE_CYCLES   = 2
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [4:0]                 start_frame,
  input  logic [4:0]                 frame_count,
  input  logic                       abort,
  frame_loader_ctrl_if.slave         stream,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
`ifdef FRAME_LOADER_CHECKSUM_EN
    CHECK  = 3'd5,
`endif
    DONE   = 3'd6
  } state_t;

  localparam logic [6:0] MaxFrames  = 7'(MaxFramesPerCol);
  localparam logic [3:0] StrobeLast = 4'(STROBE_CYCLES - 1);

  state_t                       state_q, state_d;
  logic [4:0]                   idx_q, idx_d;
  logic [4:0]                   rem_q, rem_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [FrameBitsPerRow-1:0]   data_q, data_d;
  logic [MaxFramesPerCol-1:0]   strobe_q, strobe_d;
  logic                         error_q, error_d;
`ifdef FRAME_LOADER_CHECKSUM_EN
  logic [31:0]                  sum_q, sum_d;
`endif

  logic [5:0] end_frame;
  logic       range_bad;
  logic       ready;
  logic       accept;

  // 6-bit sum so start_frame+frame_count can never wrap below the limit
  assign end_frame = {1'b0, start_frame} + {1'b0, frame_count};
  assign range_bad = {1'b0, end_frame} > MaxFrames;

`ifdef FRAME_LOADER_CHECKSUM_EN
  assign ready = ((state_q == FETCH) || (state_q == CHECK)) && !abort;
`else
  assign ready = (state_q == FETCH) && !abort;
`endif
  assign accept         = ready && stream.s_valid;
  assign stream.s_ready = ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    error_d  = error_q;
    strobe_d = '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = start_frame;
          rem_d   = frame_count;
          error_d = 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
          if (frame_count == 5'd0) begin
            state_d = DONE;
          end else if (range_bad) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (accept) begin
          data_d  = stream.s_data;
`ifdef FRAME_LOADER_CHECKSUM_EN
          sum_d   = sum_q + 32'(stream.s_data);
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == StrobeLast) state_d = HOLD;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      HOLD: begin
        idx_d = idx_q + 5'd1;
        rem_d = rem_q - 5'd1;
        if (rem_q == 5'd1) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = FETCH;
        end
      end
`ifdef FRAME_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (32'(stream.s_data) != sum_q) error_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything; DONE still falls through to IDLE so done stays a single pulse.
    if (abort && (state_q != IDLE)) begin
      error_d = 1'b1;
      if (state_q != DONE) state_d = DONE;
    end

    // Strobe is registered from the next state so the latch enables come straight off flops.
    if (state_d == STROBE) begin
      for (int i = 0; i < MaxFramesPerCol; i++) strobe_d[i] = (idx_d == 5'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      error_q  <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      error_q  <= error_d;
`ifdef FRAME_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign error       = error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_frame_loader_ctrl.sv
// Randomized bench for frame_loader_ctrl: each load is predicted from the load rules
// (range, frame list, word order, latency, error) and compared against observed strobes.
module tb_frame_loader_ctrl;
  localparam int MaxF = 20;
  localparam int W    = 32;
  localparam int SC   = 2;

  logic            CLK = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic [4:0]      start_frame = '0;
  logic [4:0]      frame_count = '0;
  logic            abort = 1'b0;
  logic [W-1:0]    FrameData;
  logic [MaxF-1:0] FrameStrobe;
  logic            busy, done, error;
  logic [2:0]      dbg_state;

  frame_loader_ctrl_if #(.W(W)) stream_if ();

  frame_loader_ctrl #(
    .MaxFramesPerCol(MaxF),
    .FrameBitsPerRow(W),
    .STROBE_CYCLES(SC)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .start(start),
    .start_frame(start_frame),
    .frame_count(frame_count),
    .abort(abort),
    .stream(stream_if),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .done(done),
    .error(error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] fixed_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] idx_of(input logic [MaxF-1:0] v);
    idx_of = '0;
    for (int i = 0; i < MaxF; i++) if (v[i]) idx_of = 5'(i);
  endfunction

  // ---------------- driver + scoreboard for one load ----------------
  task automatic run_load(input string name, input int sf, input int fc, input bit stall,
                          input int gap_word, input int abort_k, input bit chk_bad);
    logic [31:0]     words[$];
    logic [W-1:0]    src_q[$];
    logic [36:0]     exp_q[$];
    logic [36:0]     obs_q[$];
    logic [31:0]     sum;
    logic [MaxF-1:0] prev_strobe;
    logic [W-1:0]    prev_data;
    bit range_bad, exp_err, got_done, aborted, abort_pending, abort_now, gap_used;
    int exp_hs, hs, cyc, done_cyc, viol, ready_cyc, gap_left, gap_fetch, run_len, exp_lat;

    // reference model
    range_bad = (sf + fc) > MaxF;
    sum = 0;
    if (fixed_q.size() > 0) begin
      words = fixed_q;
      fixed_q.delete();
    end else begin
      for (int i = 0; i < fc; i++) words.push_back($urandom);
    end
    for (int i = 0; i < fc; i++) sum += words[i];
    exp_err = range_bad;
    exp_lat = 1;
    if (!range_bad) begin
      for (int i = 0; i < fc; i++) begin
        src_q.push_back(words[i]);
        exp_q.push_back({5'(sf + i), words[i]});
      end
      exp_lat = fc * (3 + SC) + 1;
`ifdef FRAME_LOADER_CHECKSUM_EN
      if (fc != 0) begin
        src_q.push_back(chk_bad ? sum + 32'd2 : sum);
        exp_err = chk_bad;
        exp_lat++;
      end
`endif
    end
    exp_hs = src_q.size();
    if (abort_k >= 0) begin
      while (exp_q.size() > abort_k + 1) void'(exp_q.pop_back());
      exp_hs  = abort_k + 1;
      exp_err = 1'b1;
    end

    // launch
    @(negedge CLK);
    start = 1'b1; start_frame = sf[4:0]; frame_count = fc[4:0];
    stream_if.s_valid = 1'b0;
    #1;
    prev_strobe = FrameStrobe; prev_data = FrameData;
    hs = 0; cyc = 0; done_cyc = 0; viol = 0; ready_cyc = 0; gap_left = 0; gap_fetch = 0;
    run_len = 0; got_done = 0; aborted = 0; abort_pending = 0; abort_now = 0; gap_used = 0;

    while (cyc < 3000 && !got_done) begin
      @(negedge CLK);
      cyc++;
      // start while busy must be ignored
      start = 1'($urandom_range(0, 1)); start_frame = 5'($urandom); frame_count = 5'($urandom);
      abort = abort_pending;
      abort_pending = 0;
      if (abort) aborted = 1;
      if (!gap_used && gap_word >= 0 && hs == gap_word) begin
        gap_left = 14;
        gap_used = 1;
      end
      stream_if.s_valid = (src_q.size() > 0) && (gap_left == 0) &&
                          (!stall || $urandom_range(0, 3) != 0);
      stream_if.s_data  = stream_if.s_valid ? src_q[0] : W'($urandom);
      #1;
      if (abort_now) check_eq({name, "_abort_strobe_off"}, 64'(FrameStrobe), 64'd0);
      abort_now = abort;
      if (cyc == 1) check_eq({name, "_err_at_start"}, 64'(error), 64'(range_bad));
      if (gap_left > 0) begin
        if (stream_if.s_ready) begin
          gap_fetch++;
          if (FrameStrobe != 0 || FrameData != prev_data) viol++;
        end
        gap_left--;
      end
      if (stream_if.s_ready) ready_cyc++;
      if (stream_if.s_valid && stream_if.s_ready) begin
        void'(src_q.pop_front());
        hs++;
      end
      if (FrameStrobe != prev_strobe && FrameData != prev_data) viol++;
      if ($countones(FrameStrobe) > 1) viol++;
      if (FrameStrobe != 0 && prev_strobe != 0 && FrameStrobe != prev_strobe) viol++;
      if (FrameStrobe != 0 && prev_strobe == 0) begin
        obs_q.push_back({idx_of(FrameStrobe), FrameData});
        run_len = 0;
        if (obs_q.size() == abort_k + 1) abort_pending = 1;
      end
      if (FrameStrobe != 0) run_len++;
      if (FrameStrobe != 0 && FrameData != obs_q[$][W-1:0]) viol++;
      if (FrameStrobe == 0 && prev_strobe != 0 && !aborted && run_len != SC) viol++;
      if (!busy) viol++;
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end
      prev_strobe = FrameStrobe;
      prev_data   = FrameData;
    end

    start = 1'b0; abort = 1'b0; stream_if.s_valid = 1'b0;
    @(negedge CLK);
    #1;
    check_eq({name, "_done_seen"}, 64'(got_done), 64'd1);
    check_eq({name, "_after_done"}, {62'd0, busy, done}, 64'd0);
    check_eq({name, "_error"}, 64'(error), 64'(exp_err));
    check_eq({name, "_handshakes"}, 64'(hs), 64'(exp_hs));
    check_eq({name, "_nstrobes"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_eq({name, "_strobe_idx_data"}, 64'(obs_q[i]), 64'(exp_q[i]));
    check_eq({name, "_rules"}, 64'(viol), 64'd0);
    if (range_bad || fc == 0) check_eq({name, "_ready_cycles"}, 64'(ready_cyc), 64'd0);
    if (!stall && gap_word < 0 && abort_k < 0)
      check_eq({name, "_latency"}, 64'(done_cyc), 64'(exp_lat));
    else if (abort_k < 0)
      check_eq({name, "_latency_min"}, 64'(done_cyc >= exp_lat), 64'd1);
    if (gap_word >= 0) check_eq({name, "_gap_in_fetch"}, 64'(gap_fetch >= 10), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sf, fc, ak, n;
    bit st;

    stream_if.s_valid = 1'b0;
    stream_if.s_data  = '0;
    resetn = 1'b0;
    start  = 1'($urandom_range(0, 1));
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    check_eq("rst_framedata", 64'(FrameData), 64'd0);
    check_eq("rst_strobe", 64'(FrameStrobe), 64'd0);
    check_eq("rst_ready", 64'(stream_if.s_ready), 64'd0);
    check_eq("rst_busy_done_err", {61'd0, busy, done, error}, 64'd0);
    resetn = 1'b1;

    fixed_q = '{32'hA5A5A5A5, 32'h1, 32'h2};
    run_load("three_frames", 0, 3, 0, -1, -1, 0);
    run_load("range_18_3", 18, 3, 0, -1, -1, 0);
    run_load("count_zero", 7, 0, 0, -1, -1, 0);
    run_load("abort_f5", 5, 4, 0, -1, 0, 0);
    run_load("after_abort", 0, 2, 0, -1, -1, 0);
    run_load("gap10", 2, 3, 0, 1, -1, 0);
    run_load("edge_17_3", 17, 3, 0, -1, -1, 0);
    run_load("edge_19_1", 19, 1, 0, -1, -1, 0);
    run_load("edge_20_1", 20, 1, 0, -1, -1, 0);
    run_load("nowrap_31_31", 31, 31, 0, -1, -1, 0);
`ifdef FRAME_LOADER_CHECKSUM_EN
    fixed_q = '{32'hFFFFFFFF, 32'h2};
    run_load("chk_good", 0, 2, 0, -1, -1, 0);
    fixed_q = '{32'hFFFFFFFF, 32'h2};
    run_load("chk_bad", 0, 2, 0, -1, -1, 1);
`endif

    for (int t = 0; t < 14; t++) begin
      sf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 15);
      fc = $urandom_range(0, 6);
      st = 1'($urandom_range(0, 1));
      ak = (sf + fc <= MaxF && fc > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, fc - 1) : -1;
      run_load($sformatf("rand%0d", t), sf, fc, st, -1, ak, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a strobe
    @(negedge CLK);
    start = 1'b1; start_frame = 5'd3; frame_count = 5'd2;
    stream_if.s_valid = 1'b1; stream_if.s_data = W'($urandom);
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (FrameStrobe == 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_eq("midrst_strobe_seen", 64'(FrameStrobe != 0), 64'd1);
    resetn = 1'b0;
    @(negedge CLK);
    check_eq("midrst_strobe", 64'(FrameStrobe), 64'd0);
    check_eq("midrst_data", 64'(FrameData), 64'd0);
    check_eq("midrst_busy_err", {62'd0, busy, error}, 64'd0);
    resetn = 1'b1;
    stream_if.s_valid = 1'b0;
    run_load("post_reset", 10, 2, 0, -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_loader_ctrl.md
FRAME_LOADER_CTRL -- requirements
Module: frame_loader_ctrl

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20: number of frame strobes per tile column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32: frame word width.
REQ-003 SHALL have parameter STROBE_CYCLES, default 2 (legal 1..15): FrameStrobe high time in cycles.
REQ-004 SHALL have port CLK, input, 1: the only clock; all logic on the rising edge.
REQ-005 SHALL have port resetn, input, 1: synchronous reset, active-low.
REQ-006 SHALL have port start, input, 1: launches a load when sampled high in IDLE.
REQ-007 SHALL have port start_frame, input, 5: index of the first frame to write.
REQ-008 SHALL have port frame_count, input, 5: number of consecutive frames to write.
REQ-009 SHALL have port abort, input, 1: terminates an active load.
REQ-010 SHALL have port s_data, input, FrameBitsPerRow: frame word stream.
REQ-011 SHALL have port s_valid, input, 1: s_data is valid.
REQ-012 SHALL have port s_ready, output, 1: the block accepts s_data.
REQ-013 SHALL have port FrameData, output, FrameBitsPerRow: registered word driven to the config latches.
REQ-014 SHALL have port FrameStrobe, output, MaxFramesPerCol: one-hot or zero latch enables.
REQ-015 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at load end.
REQ-017 SHALL have port error, output, 1: sticky error flag, cleared by the next accepted start.

Function
REQ-018 SHALL implement states IDLE, FETCH, SETUP, STROBE, HOLD, CHECK and DONE.
REQ-019 IDLE with start=1: SHALL latch start_frame into idx, latch frame_count into remaining, clear error, then branch:
- frame_count=0 -> DONE.
- start_frame+frame_count > MaxFramesPerCol -> set error, go to DONE; no strobe issued.
- otherwise -> FETCH.
REQ-020 FETCH: SHALL drive s_ready=1.
- On s_valid&&s_ready, register s_data into FrameData and go to SETUP.
- s_ready SHALL be 0 in all other states.
REQ-021 SETUP: SHALL last 1 cycle with FrameStrobe=0 and FrameData stable (data setup before the latch enable).
REQ-022 STROBE: SHALL drive FrameStrobe[idx]=1 for exactly STROBE_CYCLES cycles, all other strobe bits 0, FrameData unchanged.
REQ-023 HOLD: SHALL last 1 cycle with FrameStrobe=0 and FrameData still held, then:
- idx += 1 and remaining -= 1;
- if remaining becomes 0 -> CHECK when FRAME_LOADER_CHECKSUM_EN is defined, else DONE;
- otherwise -> FETCH.
REQ-024 Per-frame minimum time: 1 (FETCH) + 1 (SETUP) + STROBE_CYCLES + 1 (HOLD) cycles; s_valid low stalls FETCH indefinitely.
REQ-025 DONE: SHALL assert done=1 for 1 cycle, then go to IDLE; busy=1 during DONE.
REQ-026 At most one FrameStrobe bit SHALL ever be high; FrameStrobe SHALL never change in the same cycle as FrameData.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in any non-IDLE state SHALL force FrameStrobe=0 on the next edge, set error, and go to DONE; abort SHALL take priority over s_valid handshakes.
REQ-029 Indexes SHALL be compared at 6-bit width so start_frame+frame_count cannot wrap.

Reset
REQ-030 On CLK edge with resetn=0, the block SHALL set state=IDLE, FrameData=0, FrameStrobe=0, s_ready=0, busy=0, done=0, error=0, and idx, remaining and checksum to 0.
REQ-031 Reset mid-strobe SHALL drop FrameStrobe to 0 on that edge; latch contents are not restored.

Configuration
REQ-032 Macro FRAME_LOADER_CHECKSUM_EN defined: the block SHALL keep a 32-bit running sum (mod 2^32) of accepted data words.
- CHECK SHALL accept one extra word with s_ready=1.
- A word not equal to the sum SHALL set error; CHECK then goes to DONE.
- Abort in CHECK follows REQ-028.
REQ-033 Macro undefined: no CHECK state, no sum register, no extra word; error SHALL arise only from range or abort.

Verification
REQ-034 start_frame=0, frame_count=3, words 0xA5A5A5A5, 0x1, 0x2 with s_valid always high, STROBE_CYCLES=2 -> FrameStrobe shows bits 0, 1, 2 in turn, each high 2 cycles, each preceded and followed by one cycle with FrameStrobe=0; then done pulse, error=0.
REQ-035 start_frame=18, frame_count=3 -> no strobe, done one cycle after start, error=1, s_ready never 1.
REQ-036 frame_count=0 -> done pulse, error=0, no handshake.
REQ-037 abort asserted during STROBE of frame 5 -> FrameStrobe=0 next cycle, error=1, done pulse, later start accepted and clears error.
REQ-038 s_valid deasserted for 10 cycles in FETCH -> FrameStrobe stays 0, FrameData unchanged, resumes correctly.
REQ-039 FRAME_LOADER_CHECKSUM_EN defined, words 0xFFFFFFFF and 0x2 -> checksum word 0x1 gives error=0; checksum word 0x3 gives error=1.
